enc_8to3_hs: RTL and testbench

//   Registered 8-to-3 encoder: the inverse of the 3-to-8 decoder.

---
 rtl/enc_8to3_hs_if.sv | 22 ++
 rtl/enc_8to3_hs.sv | 107 ++++++++++
 tb/tb_enc_8to3_hs.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/enc_8to3_hs_if.sv
// Handshake bundle for the registered 8-to-3 encoder: input word stream
// (D/in_valid/in_ready) and encoded result stream (X/V/err/out_valid/out_ready).
interface enc_8to3_hs_if;
  logic [7:0] D;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] X;
  logic       V;
  logic       err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output D, in_valid, out_ready,
    input  in_ready, X, V, err, out_valid
  );

  modport slave (
    input  D, in_valid, out_ready,
    output in_ready, X, V, err, out_valid
  );
endinterface

// File: rtl/enc_8to3_hs.sv
// Registered 8-to-3 encoder with a 2-entry output FIFO.
// Each accepted word is encoded to {X, V, err} and queued. A saturating
// counter tracks accepted words that were not exactly one-hot.
module enc_8to3_hs #(
  parameter int PRIORITY_HIGH = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  enc_8to3_hs_if.slave     bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [2:0] x;
    logic       v;
    logic       err;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] occ;

  logic       in_ready_q;
  logic       out_valid_q;
  entry_t     head_q;

  entry_t     enc;
  logic       push;
  logic       pop;
  logic       rd_nxt;
  logic [1:0] occ_nxt;

  // Combinational encode of the incoming word, priority selectable.
  always_comb begin
    enc.x = '0;
    if (PRIORITY_HIGH != 0) begin
      for (int unsigned i = 0; i < 8; i++)
        if (bus.D[i]) enc.x = 3'(i);
    end else begin
      for (int unsigned i = 8; i > 0; i--)
        if (bus.D[i-1]) enc.x = 3'(i - 1);
    end
    enc.v   = (bus.D != 8'd0);
    enc.err = !((bus.D != 8'd0) && ((bus.D & (bus.D - 8'd1)) == 8'd0));
  end

  // Handshake qualifiers and next-cycle FIFO bookkeeping.
  always_comb begin
    push    = bus.in_valid & in_ready_q;
    pop     = out_valid_q & bus.out_ready;
    rd_nxt  = pop ? ~rd_ptr : rd_ptr;
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + 2'd1;
    else if (!push && pop) occ_nxt = occ - 2'd1;
  end

  // FIFO storage, pointers and registered head/ready/valid outputs.
  // The head register is loaded with whatever entry will be at rd_nxt after
  // this edge (the incoming word if it lands there), so X/V/err are pure flops
  // and simply hold when the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      mem[0]      <= '0;
      mem[1]      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= ~wr_ptr;
      end
      rd_ptr      <= rd_nxt;
      occ         <= occ_nxt;
      in_ready_q  <= (occ_nxt != 2'd2);
      out_valid_q <= (occ_nxt != 2'd0);
      if (occ_nxt != 2'd0) begin
        if (push && (wr_ptr == rd_nxt)) head_q <= enc;
        else                            head_q <= mem[rd_nxt];
      end
    end
  end

  // Saturating error counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (push && enc.err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.X         = head_q.x;
  assign bus.V         = head_q.v;
  assign bus.err       = head_q.err;

endmodule

// File: tb/tb_enc_8to3_hs.sv
// Self-checking bench for enc_8to3_hs. Two instances share the stimulus:
// dut_a (PRIORITY_HIGH=1, CNT_W=8) and dut_b (PRIORITY_HIGH=0, CNT_W=2).
module tb_enc_8to3_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic       in_valid;
  logic       out_ready;
  logic       cnt_clr;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  always #5 clk = ~clk;

  enc_8to3_hs_if ifa ();
  enc_8to3_hs_if ifb ();

  assign ifa.D         = d;
  assign ifa.in_valid  = in_valid;
  assign ifa.out_ready = out_ready;
  assign ifb.D         = d;
  assign ifb.in_valid  = in_valid;
  assign ifb.out_ready = out_ready;

  enc_8to3_hs #(.PRIORITY_HIGH(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .cnt_clr(cnt_clr), .err_cnt(cnt_a)
  );

  enc_8to3_hs #(.PRIORITY_HIGH(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .cnt_clr(cnt_clr), .err_cnt(cnt_b)
  );

  typedef struct {
    logic [7:0] d;
    logic [2:0] xa;  // expected X, highest-bit priority
    logic [2:0] xb;  // expected X, lowest-bit priority
    logic       v;
    logic       e;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [2:0] xa, input logic [2:0] xb,
                          input logic v, input logic e);
    chk({name, " ova"}, 32'(ifa.out_valid), 32'd1);
    chk({name, " xa"},  32'(ifa.X),   32'(xa));
    chk({name, " va"},  32'(ifa.V),   32'(v));
    chk({name, " ea"},  32'(ifa.err), 32'(e));
    chk({name, " ovb"}, 32'(ifb.out_valid), 32'd1);
    chk({name, " xb"},  32'(ifb.X),   32'(xb));
    chk({name, " eb"},  32'(ifb.err), 32'(e));
  endtask

  initial begin
    vecs[0]  = '{8'h01, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{8'h02, 3'd1, 3'd1, 1'b1, 1'b0};
    vecs[2]  = '{8'h04, 3'd2, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{8'h08, 3'd3, 3'd3, 1'b1, 1'b0};
    vecs[4]  = '{8'h10, 3'd4, 3'd4, 1'b1, 1'b0};
    vecs[5]  = '{8'h20, 3'd5, 3'd5, 1'b1, 1'b0};
    vecs[6]  = '{8'h40, 3'd6, 3'd6, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 3'd7, 3'd7, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 3'd0, 3'd0, 1'b0, 1'b1};
    vecs[9]  = '{8'h90, 3'd7, 3'd4, 1'b1, 1'b1};
    vecs[10] = '{8'h06, 3'd2, 3'd1, 1'b1, 1'b1};
    vecs[11] = '{8'hFF, 3'd7, 3'd0, 1'b1, 1'b1};

    rst_n = 1'b0; d = 8'h04; in_valid = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
    #23;
    chk("rst in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst cnt", 32'(cnt_a), 32'd0);
    rst_n = 1'b1;

    // First edge after release only raises in_ready; the word is not taken.
    step();
    chk("ready rises", 32'(ifa.in_ready), 32'd1);
    chk("no early accept", 32'(ifa.out_valid), 32'd0);
    step();
    chk_head("first word", 3'd2, 3'd2, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("drained", 32'(ifa.out_valid), 32'd0);
    chk("hold X when empty", 32'(ifa.X), 32'd2);

    // Streaming table: push+pop every cycle, the new word becomes head.
    for (int i = 0; i < 12; i++) begin
      d = vecs[i].d; in_valid = 1'b1;
      step();
      chk_head($sformatf("vec%0d", i), vecs[i].xa, vecs[i].xb, vecs[i].v, vecs[i].e);
      chk($sformatf("vec%0d rdy", i), 32'(ifa.in_ready), 32'd1);
      if (i == 7) chk("one-hot no err", 32'(cnt_a), 32'd0);
    end
    in_valid = 1'b0;
    step();
    chk("cnt_a after table", 32'(cnt_a), 32'd4);
    chk("cnt_b saturated", 32'(cnt_b), 32'd3);

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr a", 32'(cnt_a), 32'd0);
    chk("clr b", 32'(cnt_b), 32'd0);

    // Backpressure: two accepts fill the FIFO, third word held off.
    out_ready = 1'b0; in_valid = 1'b1; d = 8'h01;
    step();
    chk("bp rdy1", 32'(ifa.in_ready), 32'd1);
    d = 8'h02;
    step();
    chk("bp full", 32'(ifa.in_ready), 32'd0);
    d = 8'h04;
    step();
    chk("bp still full", 32'(ifa.in_ready), 32'd0);
    chk_head("bp hold", 3'd0, 3'd0, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();  // pop 0, full so 0x04 not taken
    chk_head("bp pop1", 3'd1, 3'd1, 1'b1, 1'b0);
    chk("bp rdy again", 32'(ifa.in_ready), 32'd1);
    step();  // pop 1, push 0x04
    chk_head("bp pop2", 3'd2, 3'd2, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("bp empty", 32'(ifa.out_valid), 32'd0);

    // Saturation on the narrow counter.
    d = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("sat a", 32'(cnt_a), 32'd5);
    chk("sat b", 32'(cnt_b), 32'd3);
    cnt_clr = 1'b1;
    step();  // 6th error word with clear
    cnt_clr = 1'b0;
    chk("clr beats inc a", 32'(cnt_a), 32'd0);
    chk("clr beats inc b", 32'(cnt_b), 32'd0);
    in_valid = 1'b0;
    step();

    // Reset while holding two words.
    out_ready = 1'b0; in_valid = 1'b1; d = 8'h00;
    step();
    d = 8'h30;
    step();
    in_valid = 1'b0;
    chk("pre-rst full", 32'(ifa.in_ready), 32'd0);
    chk("pre-rst cnt", 32'(cnt_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ov", 32'(ifa.out_valid), 32'd0);
    chk("async rst cnt", 32'(cnt_a), 32'd0);
    chk("async rst rdy", 32'(ifa.in_ready), 32'd0);
    #10 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("no stale %0d", i), 32'(ifa.out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
